// File: rtl/serial_pkg.sv
// Types and constants shared by the serial transmitter and receiver.
// No logic; widths and line levels only.
package serial_pkg;

  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/odd_parity.sv
// Odd-parity generator: output makes data plus parity hold an odd number of 1s.
// Combinational, zero latency, no flow control.
module odd_parity
  import serial_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  assign parity = ~^data;

endmodule

// File: rtl/serial_tx.sv
// Byte-to-serial framer: start, 8 data bits LSB first, optional odd parity, 1-2 stop bits.
// Start bit on the line the cycle after accept; in_ready only in IDLE and the final stop cycle.
module serial_tx
  import serial_pkg::*;
#(
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 par, par_nxt;
  logic                 par_in;
  logic                 tx_nxt;
  logic                 last_stop;
  logic                 accept;

  // Parity is taken from the incoming byte at accept, since the shift register
  // is consumed as bits go out.
  odd_parity u_odd_parity (
    .data   (in_data),
    .parity (par_in)
  );

  assign last_stop = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));
  assign in_ready  = (state == IDLE) || last_stop;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign done      = last_stop;

  // tx_nxt is the level for the state being entered, so tx_out is a plain flop
  // that always shows the bit belonging to the current state.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par;
    tx_nxt       = tx_out;
    case (state)
      IDLE: begin
        tx_nxt = STOP_BIT;
        if (accept) begin
          state_nxt = START;
          tx_nxt    = START_BIT;
          shreg_nxt = in_data;
          par_nxt   = par_in;
        end
      end
      START: begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
        tx_nxt      = shreg[0];
        shreg_nxt   = {1'b0, shreg[DATA_BITS-1:1]};
      end
      DATA: begin
        if (bit_cnt == 3'(DATA_BITS - 1)) begin
          stop_cnt_nxt = 1'b0;
          if (PARITY_EN != 0) begin
            state_nxt = PARITY;
            tx_nxt    = par;
          end else begin
            state_nxt = STOP;
            tx_nxt    = STOP_BIT;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          tx_nxt      = shreg[0];
          shreg_nxt   = {1'b0, shreg[DATA_BITS-1:1]};
        end
      end
      PARITY: begin
        state_nxt    = STOP;
        stop_cnt_nxt = 1'b0;
        tx_nxt       = STOP_BIT;
      end
      STOP: begin
        tx_nxt = STOP_BIT;
        if (last_stop) begin
          if (accept) begin
            state_nxt = START;
            tx_nxt    = START_BIT;
            shreg_nxt = in_data;
            par_nxt   = par_in;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          stop_cnt_nxt = stop_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx_out   <= STOP_BIT;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      par      <= par_nxt;
      tx_out   <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: parity and no-parity/two-stop configurations.
// Observed vector per cycle is {tx_out, busy, in_ready, done}, sampled on the falling edge.
module tb_serial_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, in_ready, tx_out, busy, done;
  logic [7:0] in_data;
  logic       reset2, in_valid2, in_ready2, tx_out2, busy2, done2;
  logic [7:0] in_data2;

  int n_checks = 0;
  int n_fail   = 0;

  serial_tx #(.PARITY_EN(1), .STOP_BITS(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_out   (tx_out),
    .busy     (busy),
    .done     (done)
  );

  serial_tx #(.PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .clk      (clk),
    .reset    (reset2),
    .in_data  (in_data2),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .tx_out   (tx_out2),
    .busy     (busy2),
    .done     (done2)
  );

  // Expected {tx_out, busy, in_ready, done} for cycle c (1 = start bit) of a
  // parity-enabled, one-stop-bit frame; p is the hand-computed parity bit.
  function automatic logic [3:0] exp_frame(input logic [7:0] b, input logic p, input int c);
    logic [3:0] e;
    if (c == 1)       e = 4'b0100;
    else if (c <= 9)  e = {b[c-2], 3'b100};
    else if (c == 10) e = {p, 3'b100};
    else              e = 4'b1111;
    return e;
  endfunction

  task automatic test_reset();
    reset     = 1'b1;
    reset2    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    in_valid2 = 1'b1;
    in_data2  = 8'hAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_dut1: got %b expected 1010", {tx_out, busy, in_ready, done});
    end
    n_checks++;
    if ({tx_out2, busy2, in_ready2, done2} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_dut2: got %b expected 1010", {tx_out2, busy2, in_ready2, done2});
    end
    reset     = 1'b0;
    reset2    = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got %b expected 1010", {tx_out, busy, in_ready, done});
    end
  endtask

  // Sends one byte on dut; optionally scrambles in_valid/in_data while busy.
  task automatic test_frame(input string name, input logic [7:0] b, input logic p, input bit scramble);
    logic [3:0] obs;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 11; c++) begin
      obs = {tx_out, busy, in_ready, done};
      n_checks++;
      if (obs !== exp_frame(b, p, c)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, c, obs, exp_frame(b, p, c));
      end
      if (scramble && c <= 9) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL %s idle_after: got %b expected 1010", name, {tx_out, busy, in_ready, done});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    in_data  = 8'h01;
    in_valid = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 22; c++) begin
      obs = {tx_out, busy, in_ready, done};
      exp = (c <= 11) ? exp_frame(8'h01, 1'b0, c) : exp_frame(8'h80, 1'b0, c - 11);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp);
      end
      if (c == 1) in_data = 8'h80;
      if (c == 12) in_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL back_to_back idle_after: got %b expected 1010", {tx_out, busy, in_ready, done});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] obs;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      obs = {tx_out, busy, in_ready, done};
      n_checks++;
      if (obs !== exp_frame(8'h3C, 1'b1, c)) begin
        n_fail++;
        $display("FAIL mid_reset_pre cycle %0d: got %b expected %b", c, obs, exp_frame(8'h3C, 1'b1, c));
      end
      in_valid = 1'b0;
      if (c < 5) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got %b expected 1010", {tx_out, busy, in_ready, done});
    end
    // Handshake offered while reset is still high must be dropped.
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_discard_accept: got %b expected 1010", {tx_out, busy, in_ready, done});
    end
    @(negedge clk);
    n_checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL mid_reset_no_resume: got %b expected 1010", {tx_out, busy, in_ready, done});
    end
    test_frame("after_reset_55", 8'h55, 1'b1, 1'b0);
  endtask

  task automatic test_no_parity_two_stop();
    logic [3:0] obs, exp;
    in_data2  = 8'h00;
    in_valid2 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 11; c++) begin
      obs = {tx_out2, busy2, in_ready2, done2};
      if (c <= 9)       exp = 4'b0100;
      else if (c == 10) exp = 4'b1100;
      else              exp = 4'b1111;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL two_stop cycle %0d: got %b expected %b", c, obs, exp);
      end
      in_valid2 = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if ({tx_out2, busy2, in_ready2, done2} !== 4'b1010) begin
      n_fail++;
      $display("FAIL two_stop idle_after: got %b expected 1010", {tx_out2, busy2, in_ready2, done2});
    end
  endtask

  initial begin
    test_reset();
    test_frame("frame_A5", 8'hA5, 1'b1, 1'b0);
    test_frame("frame_01", 8'h01, 1'b0, 1'b0);
    test_frame("frame_FF", 8'hFF, 1'b1, 1'b0);
    test_back_to_back();
    test_reset_mid_frame();
    test_no_parity_two_stop();
    test_frame("scrambled_C3", 8'hC3, 1'b1, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
